// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and capture blocks: default widths,
// idle timeout and the capture FSM state encoding.
package pwm_pkg;

  localparam int TOP_WIDTH_DEF = 8;
  localparam int CMP_WIDTH_DEF = 9;
  localparam int TIMEOUT_DEF   = 1024;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STUCK   = 2'd2
  } state_t;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level into the clk domain.
// No reset, so a held input level never produces a spurious edge after reset.
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// Recovers PWM period (top) and high time (compare) from a single input pin,
// with stuck-level detection for 0%/100% duty and overrange flagging.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int TOP_WIDTH = TOP_WIDTH_DEF,
  parameter int CMP_WIDTH = CMP_WIDTH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pwm,
  output logic [TOP_WIDTH-1:0] o_top,
  output logic                 o_top_valid,
  output logic [CMP_WIDTH-1:0] o_compare,
  output logic                 o_compare_valid,
  output logic                 o_stuck,
  output logic                 o_level,
  output logic                 o_overrange,
  output state_t               o_state
);

  localparam int CW = TOP_WIDTH + 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] PERIOD_MAX = {1'b1, {TOP_WIDTH{1'b0}}};
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic s, d;
  logic rise, fall, edge_seen, idle_hit;

  state_t state, state_n;
  logic [CW-1:0] period_cnt, period_n;
  logic [CW-1:0] high_cnt, high_n;
  logic [IW-1:0] idle_cnt;

  logic [TOP_WIDTH-1:0] top_n;
  logic [CMP_WIDTH-1:0] cmp_n;
  logic tv_n, cv_n, stuck_n, level_n, ovr_n;

  synchronizer #(.STAGES(2)) u_sync (
    .clk (i_clk),
    .d   (i_pwm),
    .q   (s)
  );

  always_ff @(posedge i_clk) begin
    d <= s;
  end

  assign rise      = s & ~d;
  assign fall      = ~s & d;
  assign edge_seen = rise | fall;
  // Fires on the cycle idle_cnt steps onto TIMEOUT; a rise in that cycle wins.
  assign idle_hit  = !edge_seen && (idle_cnt == IW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idle_cnt <= '0;
    end else if (edge_seen) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IW'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // Strobes are single-cycle valids with no ready: the consumer must take
  // o_top/o_compare on the cycle its valid is high; there is no backpressure.
  always_comb begin
    state_n  = state;
    period_n = period_cnt;
    high_n   = high_cnt;
    top_n    = o_top;
    cmp_n    = o_compare;
    tv_n     = 1'b0;
    cv_n     = 1'b0;
    stuck_n  = o_stuck;
    level_n  = o_level;
    ovr_n    = o_overrange;
    case (state)
      ST_WAIT: begin
        if (rise) begin
          state_n  = ST_MEASURE;
          period_n = CNT_ONE;
          high_n   = CNT_ONE;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          if (period_cnt <= PERIOD_MAX) begin
            top_n = TOP_WIDTH'(period_cnt - CNT_ONE);
            cmp_n = CMP_WIDTH'(high_cnt);
            tv_n  = 1'b1;
            cv_n  = 1'b1;
            ovr_n = 1'b0;
          end else begin
            ovr_n = 1'b1;
          end
          period_n = CNT_ONE;
          high_n   = CNT_ONE;
        end else if (idle_hit) begin
          state_n = ST_STUCK;
          stuck_n = 1'b1;
          level_n = s;
          cv_n    = 1'b1;
          cmp_n   = s ? CMP_WIDTH'({1'b0, o_top} + CNT_ONE) : '0;
        end else begin
          period_n = (period_cnt == CNT_MAX) ? period_cnt : period_cnt + CNT_ONE;
          if (s) begin
            high_n = (high_cnt == CNT_MAX) ? high_cnt : high_cnt + CNT_ONE;
          end
        end
      end
      ST_STUCK: begin
        if (rise) begin
          state_n  = ST_MEASURE;
          stuck_n  = 1'b0;
          level_n  = 1'b0;
          period_n = CNT_ONE;
          high_n   = CNT_ONE;
        end else if (fall) begin
          state_n = ST_WAIT;
          stuck_n = 1'b0;
          level_n = 1'b0;
        end
      end
      default: state_n = ST_WAIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= ST_WAIT;
      period_cnt      <= '0;
      high_cnt        <= '0;
      o_top           <= '0;
      o_compare       <= '0;
      o_top_valid     <= 1'b0;
      o_compare_valid <= 1'b0;
      o_stuck         <= 1'b0;
      o_level         <= 1'b0;
      o_overrange     <= 1'b0;
    end else begin
      state           <= state_n;
      period_cnt      <= period_n;
      high_cnt        <= high_n;
      o_top           <= top_n;
      o_compare       <= cmp_n;
      o_top_valid     <= tv_n;
      o_compare_valid <= cv_n;
      o_stuck         <= stuck_n;
      o_level         <= level_n;
      o_overrange     <= ovr_n;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: waveform segments drive the pin, a segment-level model
// predicts strobes into a queue, and a negedge monitor pops and compares them.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int TW = 8;
  localparam int CWID = 9;
  localparam int TO = 1024;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_in = 1'b0;
  logic [TW-1:0] top;
  logic top_valid;
  logic [CWID-1:0] cmp;
  logic cmp_valid, stuck, level, ovr;
  state_t dbg_state;

  always #5 clk = ~clk;

  pwm_capture #(.TOP_WIDTH(TW), .CMP_WIDTH(CWID), .TIMEOUT(TO)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_pwm           (pwm_in),
    .o_top           (top),
    .o_top_valid     (top_valid),
    .o_compare       (cmp),
    .o_compare_valid (cmp_valid),
    .o_stuck         (stuck),
    .o_level         (level),
    .o_overrange     (ovr),
    .o_state         (dbg_state)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected entry: {stuck_kind, level, top[7:0], compare[8:0]}
  logic [18:0] exp_q[$];

  typedef enum {M_WAIT, M_MEAS, M_STUCK} mstate_t;
  mstate_t m_state = M_WAIT;
  bit m_lvl = 1'b0;
  int m_period = 0;
  int m_high = 0;
  int m_run = 0;
  int m_top = 0;
  bit m_ovr = 1'b0;

  // A segment holds the pin at lvl for len clocks; a level change at its start
  // is an edge. Period = clocks from one rise to the next, high = clocks high.
  task automatic model_seg(input bit lvl, input int len);
    logic [18:0] e;
    if (lvl != m_lvl) begin
      if (lvl) begin
        if (m_state == M_MEAS) begin
          if (m_period <= (1 << TW)) begin
            e = {1'b0, 1'b0, TW'(m_period - 1), CWID'(m_high)};
            exp_q.push_back(e);
            m_top = m_period - 1;
            m_ovr = 1'b0;
          end else begin
            m_ovr = 1'b1;
          end
        end
        m_state = M_MEAS;
        m_period = 0;
        m_high = 0;
      end else if (m_state == M_STUCK) begin
        m_state = M_WAIT;
      end
      m_run = len - 1;
    end else begin
      m_run += len;
    end
    m_period += len;
    if (lvl) m_high += len;
    m_lvl = lvl;
    if (m_state == M_MEAS && m_run >= TO) begin
      e = {1'b1, lvl, TW'(m_top), CWID'(lvl ? m_top + 1 : 0)};
      exp_q.push_back(e);
      m_state = M_STUCK;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_seg(input bit lvl, input int len);
    model_seg(lvl, len);
    pwm_in = lvl;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
    if (len >= 4) check("overrange", ovr, m_ovr);
  endtask

  task automatic reset_dut(input int cycles);
    check("queue_empty_at_reset", exp_q.size(), 0);
    rst = 1'b1;
    m_state = M_WAIT;
    m_ovr = 1'b0;
    m_top = 0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_top", top, 0);
    check("rst_compare", cmp, 0);
    check("rst_top_valid", top_valid, 0);
    check("rst_compare_valid", cmp_valid, 0);
    check("rst_stuck", stuck, 0);
    check("rst_level", level, 0);
    check("rst_overrange", ovr, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [18:0] mon_e;
  always @(negedge clk) begin
    if (!rst && (top_valid || cmp_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("compare_valid", cmp_valid, 1);
        check("top_valid", top_valid, mon_e[18] ? 0 : 1);
        check("top", top, mon_e[16:9]);
        check("compare", cmp, mon_e[8:0]);
        check("stuck_at_strobe", stuck, mon_e[18]);
        check("level_at_strobe", level, mon_e[17]);
        if (!mon_e[18]) check("overrange_at_strobe", ovr, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int p, h;
    reset_dut(4);
    drive_seg(0, 20);

    // top=255 compare=128, then compare changes to 40
    repeat (6) begin drive_seg(1, 128); drive_seg(0, 128); end
    repeat (4) begin drive_seg(1, 40); drive_seg(0, 216); end

    // held low -> stuck at 0, then resume
    drive_seg(0, 1200);
    check("stuck_low", stuck, 1);
    check("stuck_low_level", level, 0);
    repeat (3) begin drive_seg(1, 100); drive_seg(0, 156); end
    check("stuck_cleared", stuck, 0);

    // held high after a 256-clock period -> stuck at 1, compare=256
    drive_seg(1, 1300);
    check("stuck_high", stuck, 1);
    check("stuck_high_level", level, 1);
    drive_seg(0, 50);
    check("stuck_fall_clear", stuck, 0);
    drive_seg(1, 30); drive_seg(0, 30);

    // 300-clock period overrange, then 200-clock period clears it
    drive_seg(1, 100); drive_seg(0, 200);
    drive_seg(1, 60); drive_seg(0, 140);
    drive_seg(1, 20); drive_seg(0, 20);

    // idle boundary: 1024 quiet clocks is not stuck, 1025 is
    drive_seg(1, 5); drive_seg(0, 1024);
    drive_seg(1, 5); drive_seg(0, 1025);
    drive_seg(1, 5); drive_seg(0, 10);

    // glitches and exact 256 / 257 periods
    drive_seg(1, 1); drive_seg(0, 2);
    drive_seg(1, 1); drive_seg(0, 255);
    drive_seg(1, 1); drive_seg(0, 256);
    drive_seg(1, 2); drive_seg(0, 4);

    // randomized periods with occasional long holds
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(2, 300);
      h = $urandom_range(1, p - 1);
      drive_seg(1, h);
      drive_seg(0, p - h);
      if ($urandom_range(0, 7) == 0) drive_seg($urandom_range(0, 1) == 1, $urandom_range(1000, 1100));
    end

    // reset mid-high-phase discards the partial period
    drive_seg(0, 20);
    drive_seg(1, 50);
    reset_dut(1);
    drive_seg(1, 60); drive_seg(0, 100);
    drive_seg(1, 80); drive_seg(0, 80);
    drive_seg(1, 50); drive_seg(0, 70);
    drive_seg(1, 10);

    repeat (8) @(posedge clk);
    #1;
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive side of the PWM audio output: samples a PWM waveform on a single pin and recovers the period (top) and high time (compare) that produced it.
- Outputs match the `pwm` input interface: top/compare with one-cycle valid strobes. A capture-to-`pwm` loopback therefore reproduces the generator's settings.
- Used for on-board self-test of the mixer output and for measuring external PWM sources on a PMOD input.

Parameters:
- TOP_WIDTH, 8, width of recovered top; maximum measurable period is 2^TOP_WIDTH clocks.
- CMP_WIDTH, 9, width of recovered compare; must be at least TOP_WIDTH+1.
- TIMEOUT, 1024, clocks without any input edge before the block declares a stuck level; must be greater than 2^TOP_WIDTH.

Ports:
- i_clk  input  1  system clock; the only clock.
- i_rst  input  1  synchronous, active-high reset.
- i_pwm  input  1  asynchronous PWM waveform.
- o_top  output  TOP_WIDTH  recovered period minus 1.
- o_top_valid  output  1  one-cycle strobe; o_top updated this cycle.
- o_compare  output  CMP_WIDTH  recovered high-time in clocks.
- o_compare_valid  output  1  one-cycle strobe; o_compare updated this cycle.
- o_stuck  output  1  input has had no edge for TIMEOUT clocks.
- o_level  output  1  synchronized level while o_stuck=1; 0 otherwise.
- o_overrange  output  1  last period exceeded 2^TOP_WIDTH clocks.

Behaviour:
- **Input path:** i_pwm passes through a 2-flop synchronizer (s), then a 1-flop delay (d).
  - rise = s & ~d; fall = ~s & d.
  - Fixed latency of 3 clocks from i_pwm to edge detection.
- **Reset:** all outputs are 0. State is WAIT. Counters clear. Reset asserted mid-period discards the partial measurement; no strobe is issued.
- **Counters:**
  - period_cnt and high_cnt are TOP_WIDTH+1 bits wide and saturate at all-ones.
  - idle_cnt counts up to TIMEOUT and clears on any edge.
- **States:**
  - WAIT: ignore everything until rise. On rise: period_cnt=1, high_cnt=1, go to MEASURE. No strobe, because the first partial period is discarded.
  - MEASURE, each cycle without rise: period_cnt+1; high_cnt+1 if s=1.
  - MEASURE, on rise:
    - If period_cnt <= 2^TOP_WIDTH: in the same cycle set o_top=period_cnt-1 and o_compare=high_cnt, pulse both valids, and clear o_overrange.
    - Otherwise: set o_overrange=1, issue no strobe, leave outputs unchanged.
    - In both cases, restart the counters at 1 and stay in MEASURE.
  - MEASURE, idle_cnt reaches TIMEOUT: go to STUCK.
    - Set o_stuck=1 and o_level=s.
    - Pulse o_compare_valid once with o_compare = s ? o_top+1 : 0. o_top is held.
    - This represents 0% or 100% duty at the last known period.
  - STUCK: on rise, clear o_stuck and o_level, set period_cnt=1 and high_cnt=1, go to MEASURE. On fall, clear o_stuck and o_level and go to WAIT.
- **Strobes:**
  - o_top_valid and o_compare_valid are each high for exactly one cycle per event. Both fire together except on STUCK entry, where only o_compare_valid fires.
  - Strobes are never issued back-to-back; the minimum spacing is 2 clocks, because a period requires both a rise and a fall.
- **Simultaneous events:** rise and idle_cnt reaching TIMEOUT in the same cycle: rise wins and the period is judged as above (it will be overrange).
- **Glitches:** no filtering. A 1-clock pulse produces a valid measurement with compare=1.

Decomposition:
- Shared package `pwm_pkg` holds:
  - the state encoding localparams (WAIT, MEASURE, STUCK);
  - the default TOP_WIDTH, CMP_WIDTH and TIMEOUT constants, shared with `pwm`.
- Sub-module: reuse the existing `synchronizer` for the 2-flop input stage.
- Edge detect, counters and FSM live in pwm_capture itself.

Test Plan:
1. `pwm` drives the input with top=255, compare=128, looped back.
   - After the second rise: o_top=255, o_compare=128, both valids pulse once per 256 clocks, o_stuck=0.
2. compare changes from 128 to 40 mid-stream.
   - Within 2 periods: o_compare=40, o_top stays 255, no spurious strobes.
3. compare=0, input held low.
   - Exactly 1024 clocks after the last fall: o_stuck=1, o_level=0, o_compare_valid pulses with o_compare=0.
   - Resuming toggling clears o_stuck.
4. compare=256, input held high with top=255.
   - On timeout: o_level=1, o_compare=256.
5. Manual waveform: 300-clock period, 100 clocks high.
   - o_overrange=1, no valid strobes.
   - A following 200-clock period clears it and reports o_top=199.
6. Assert i_rst for 1 cycle mid-high-phase.
   - All outputs are 0 the next cycle.
   - The first strobe appears only after two further rises.
